// File: rtl/mips_cpu_harvard_core.sv
// Single-cycle MIPS-I subset core on split instruction/data buses,
// with branch delay slot and halt on a jump to address 0.
// Ports:
//   clk, reset (sync, active-high), clk_enable (hold when 0)
//   active, register_v0 : run flag and live $2
//   instr_address/instr_readdata : fetch bus, combinational read
//   data_address/data_write/data_read/data_writedata/data_readdata
module mips_cpu_harvard_core #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_write,
  output logic        data_read,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  localparam logic [31:0] STEP = 32'd4;

  // Initializers give the same state as a reset edge at power-up.
  logic [31:0] pc      = RESET_VECTOR;
  logic [31:0] pc_next = RESET_VECTOR + STEP;
  logic        run     = 1'b1;
  logic [31:0] gpr [32] = '{default: 32'd0};

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sh;
  logic [15:0] imm;

  assign op  = instr_readdata[31:26];
  assign rs  = instr_readdata[25:21];
  assign rt  = instr_readdata[20:16];
  assign rd  = instr_readdata[15:11];
  assign sh  = instr_readdata[10:6];
  assign fn  = instr_readdata[5:0];
  assign imm = instr_readdata[15:0];

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sext;
  logic [31:0] zext;
  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] link;

  // $0 is never written, so a plain read returns zero.
  assign a      = gpr[rs];
  assign b      = gpr[rt];
  assign sext   = {{16{imm[15]}}, imm};
  assign zext   = {16'd0, imm};
  assign pc4    = pc + STEP;
  assign br_tgt = pc4 + {sext[29:0], 2'b00};
  assign j_tgt  = {pc4[31:28], instr_readdata[25:0], 2'b00};
  assign link   = pc + 32'd8;

  logic        wen;
  logic [4:0]  wdst;
  logic [31:0] wval;
  logic        taken;
  logic [31:0] tgt;
  logic        is_lw;
  logic        is_sw;

  always_comb begin
    wen   = 1'b0;
    wdst  = rt;
    wval  = 32'd0;
    taken = 1'b0;
    tgt   = br_tgt;
    is_lw = 1'b0;
    is_sw = 1'b0;
    unique case (op)
      6'h00: begin
        wdst = rd;
        unique case (fn)
          6'h00: begin wen = 1'b1; wval = b << sh; end
          6'h02: begin wen = 1'b1; wval = b >> sh; end
          6'h03: begin
            wen  = 1'b1;
            wval = $unsigned($signed(b) >>> sh);
          end
          6'h04: begin wen = 1'b1; wval = b << a[4:0]; end
          6'h06: begin wen = 1'b1; wval = b >> a[4:0]; end
          6'h07: begin
            wen  = 1'b1;
            wval = $unsigned($signed(b) >>> a[4:0]);
          end
          6'h08: begin taken = 1'b1; tgt = a; end
          6'h09: begin
            taken = 1'b1;
            tgt   = a;
            wen   = 1'b1;
            wval  = link;
          end
          6'h21: begin wen = 1'b1; wval = a + b; end
          6'h23: begin wen = 1'b1; wval = a - b; end
          6'h24: begin wen = 1'b1; wval = a & b; end
          6'h25: begin wen = 1'b1; wval = a | b; end
          6'h26: begin wen = 1'b1; wval = a ^ b; end
          6'h27: begin wen = 1'b1; wval = ~(a | b); end
          6'h2A: begin
            wen  = 1'b1;
            wval = {31'd0, $signed(a) < $signed(b)};
          end
          6'h2B: begin wen = 1'b1; wval = {31'd0, a < b}; end
          default: ;
        endcase
      end
      // REGIMM: rt selects BLTZ (0) or BGEZ (1).
      6'h01: taken = (rt == 5'd0 && a[31]) ||
                     (rt == 5'd1 && !a[31]);
      6'h02: begin taken = 1'b1; tgt = j_tgt; end
      6'h03: begin
        taken = 1'b1;
        tgt   = j_tgt;
        wen   = 1'b1;
        wdst  = 5'd31;
        wval  = link;
      end
      6'h04: taken = (a == b);
      6'h05: taken = (a != b);
      6'h06: taken = a[31] || (a == 32'd0);
      6'h07: taken = !a[31] && (a != 32'd0);
      6'h09: begin wen = 1'b1; wval = a + sext; end
      6'h0A: begin
        wen  = 1'b1;
        wval = {31'd0, $signed(a) < $signed(sext)};
      end
      6'h0B: begin wen = 1'b1; wval = {31'd0, a < sext}; end
      6'h0C: begin wen = 1'b1; wval = a & zext; end
      6'h0D: begin wen = 1'b1; wval = a | zext; end
      6'h0E: begin wen = 1'b1; wval = a ^ zext; end
      6'h0F: begin wen = 1'b1; wval = {imm, 16'd0}; end
      6'h23: begin
        is_lw = 1'b1;
        wen   = 1'b1;
        wval  = data_readdata;
      end
      6'h2B: is_sw = 1'b1;
      default: ;
    endcase
  end

  assign active         = run;
  assign register_v0    = gpr[2];
  assign instr_address  = pc;
  assign data_address   = a + sext;
  assign data_writedata = b;
  assign data_read      = run & is_lw;
  assign data_write     = run & is_sw;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= RESET_VECTOR;
      pc_next <= RESET_VECTOR + STEP;
      run     <= 1'b1;
      for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
    end else if (clk_enable && run) begin
      pc      <= pc_next;
      pc_next <= taken ? tgt : pc_next + STEP;
      // Entering address 0 (delay slot done) stops the core.
      if (pc_next == 32'd0) run <= 1'b0;
      if (wen && wdst != 5'd0) gpr[wdst] <= wval;
    end
  end

endmodule

// File: tb/tb_mips_cpu_harvard_core.sv
// Self-checking bench for mips_cpu_harvard_core: directed programs
// plus random programs run in lockstep with an instruction-level model.
module tb_mips_cpu_harvard_core;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b0;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  logic [31:0] imem [256];
  logic [31:0] dmem [64];
  logic [31:0] dm_seed [64];
  logic        dm_load = 1'b0;

  int total = 0;
  int bad = 0;

  logic [31:0] m_pc;
  logic [31:0] m_npc;
  logic [31:0] m_gpr [32];
  logic [31:0] m_dmem [64];
  logic        m_active;

  mips_cpu_harvard_core dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .register_v0    (register_v0),
    .clk_enable     (clk_enable),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  always #5 clk = ~clk;

  logic [31:0] ioff;
  always_comb begin
    ioff = instr_address - RV;
    instr_readdata = (ioff < 32'd1024) ? imem[ioff[9:2]] : 32'd0;
  end

  assign data_readdata = dmem[data_address[7:2]];

  always @(posedge clk) begin
    if (dm_load) dmem <= dm_seed;
    else if (clk_enable && data_write)
      dmem[data_address[7:2]] <= data_writedata;
  end

  function automatic logic [31:0] r_t(
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [4:0] sh,
    input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_t(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic logic [31:0] j_t(
    input logic [5:0] op, input logic [31:0] dest);
    return {op, dest[27:2]};
  endfunction

  function automatic logic [31:0] m_fetch(input logic [31:0] addr);
    longint off;
    off = longint'(addr) - longint'(RV);
    if (off >= 0 && off < 1024) return imem[int'(off / 4)];
    return 32'd0;
  endfunction

  // One instruction, computed from the ISA rules.
  task automatic model_step();
    logic [31:0] w, s, t, se, res, nxt, bt, ea;
    logic [4:0]  dst;
    int          sa;
    if (!m_active) return;
    w   = m_fetch(m_pc);
    s   = m_gpr[w[25:21]];
    t   = m_gpr[w[20:16]];
    se  = {{16{w[15]}}, w[15:0]};
    sa  = int'(w[10:6]);
    bt  = m_pc + 32'd4 + se * 32'd4;
    ea  = s + se;
    nxt = m_npc + 32'd4;
    dst = 5'd0;
    res = 32'd0;
    case (w[31:26])
      6'h00: begin
        dst = w[15:11];
        case (w[5:0])
          6'h00: res = t << sa;
          6'h02: res = t >> sa;
          6'h03: res = 32'(int'(t) >>> sa);
          6'h04: res = t << s[4:0];
          6'h06: res = t >> s[4:0];
          6'h07: res = 32'(int'(t) >>> s[4:0]);
          6'h08: begin dst = 5'd0; nxt = s; end
          6'h09: begin nxt = s; res = m_pc + 32'd8; end
          6'h21: res = s + t;
          6'h23: res = s - t;
          6'h24: res = s & t;
          6'h25: res = s | t;
          6'h26: res = s ^ t;
          6'h27: res = ~(s | t);
          6'h2A: res = (int'(s) < int'(t)) ? 32'd1 : 32'd0;
          6'h2B: res = (longint'(s) < longint'(t)) ? 32'd1 : 32'd0;
          default: dst = 5'd0;
        endcase
      end
      6'h01: begin
        if (w[20:16] == 5'd0 && int'(s) < 0) nxt = bt;
        if (w[20:16] == 5'd1 && int'(s) >= 0) nxt = bt;
      end
      6'h02: nxt = ((m_pc + 32'd4) & 32'hF000_0000) | {4'd0, w[25:0], 2'b00};
      6'h03: begin
        nxt = ((m_pc + 32'd4) & 32'hF000_0000) | {4'd0, w[25:0], 2'b00};
        dst = 5'd31;
        res = m_pc + 32'd8;
      end
      6'h04: if (s == t) nxt = bt;
      6'h05: if (s != t) nxt = bt;
      6'h06: if (int'(s) <= 0) nxt = bt;
      6'h07: if (int'(s) > 0) nxt = bt;
      6'h09: begin dst = w[20:16]; res = s + se; end
      6'h0A: begin dst = w[20:16]; res = (int'(s) < int'(se)) ? 32'd1 : 32'd0; end
      6'h0B: begin dst = w[20:16]; res = (longint'(s) < longint'(se)) ? 32'd1 : 32'd0; end
      6'h0C: begin dst = w[20:16]; res = s & 32'(w[15:0]); end
      6'h0D: begin dst = w[20:16]; res = s | 32'(w[15:0]); end
      6'h0E: begin dst = w[20:16]; res = s ^ 32'(w[15:0]); end
      6'h0F: begin dst = w[20:16]; res = 32'(w[15:0]) * 32'h10000; end
      6'h23: begin dst = w[20:16]; res = m_dmem[(ea >> 2) % 64]; end
      6'h2B: m_dmem[(ea >> 2) % 64] = t;
      default: ;
    endcase
    if (dst != 5'd0) m_gpr[dst] = res;
    m_pc  = m_npc;
    m_npc = nxt;
    if (m_pc == 32'd0) m_active = 1'b0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clk_enable = 1'b1;
    dm_load = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dm_load = 1'b0;
    m_pc = RV;
    m_npc = RV + 32'd4;
    m_active = 1'b1;
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
    m_dmem = dm_seed;
  endtask

  task automatic load_count_prog(input logic [5:0] bop, input logic [4:0] r1, input logic [4:0] r2);
    clear_imem();
    imem[0] = i_t(bop, r1, r2, 16'd2);
    imem[1] = i_t(6'h09, 5'd2, 5'd2, 16'd1);
    imem[2] = i_t(6'h09, 5'd2, 5'd2, 16'd1);
    imem[3] = i_t(6'h09, 5'd2, 5'd2, 16'd1);
    imem[4] = r_t(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
    imem[5] = 32'd0;
  endtask

  task automatic wait_halt(input string nm);
    for (int c = 0; c < 100 && instr_address !== 32'd0; c++) @(negedge clk);
    total++;
    if (instr_address !== 32'd0) begin
      bad++;
      $display("FAIL %s_halt_timeout pc=%h want=00000000", nm, instr_address);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (instr_address !== RV) begin
      bad++; $display("FAIL pwrup_pc got=%h want=%h", instr_address, RV);
    end
    total++;
    if (active !== 1'b1) begin
      bad++; $display("FAIL pwrup_active got=%b want=1", active);
    end
    total++;
    if (register_v0 !== 32'd0) begin
      bad++; $display("FAIL pwrup_v0 got=%h want=0", register_v0);
    end
    total++;
    if (data_write !== 1'b0 || data_read !== 1'b0) begin
      bad++; $display("FAIL pwrup_bus got=%b%b want=00", data_write, data_read);
    end
  endtask

  task automatic test_beq();
    load_count_prog(6'h04, 5'd3, 5'd4);
    @(negedge clk);
    clk_enable = 1'b1;
    wait_halt("beq");
    total++;
    if (register_v0 !== 32'd2) begin
      bad++; $display("FAIL beq_v0 got=%h want=2", register_v0);
    end
    total++;
    if (active !== 1'b0) begin
      bad++; $display("FAIL beq_active got=%b want=0", active);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (instr_address !== 32'd0 || active !== 1'b0 || register_v0 !== 32'd2) begin
        bad++;
        $display("FAIL halt_hold pc=%h act=%b v0=%h want=0/0/2",
                 instr_address, active, register_v0);
      end
    end
  endtask

  task automatic test_bne();
    load_count_prog(6'h05, 5'd0, 5'd0);
    do_reset();
    wait_halt("bne");
    total++;
    if (register_v0 !== 32'd3) begin
      bad++; $display("FAIL bne_v0 got=%h want=3", register_v0);
    end
  endtask

  task automatic test_load_store();
    clear_imem();
    for (int i = 0; i < 64; i++) dm_seed[i] = 32'd0;
    imem[0] = i_t(6'h0F, 5'd0, 5'd5, 16'h1234);
    imem[1] = i_t(6'h0D, 5'd5, 5'd5, 16'h5678);
    imem[2] = i_t(6'h2B, 5'd0, 5'd5, 16'd4);
    imem[3] = i_t(6'h23, 5'd0, 5'd2, 16'd4);
    imem[4] = r_t(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
    do_reset();
    for (int c = 0; c < 10 && instr_address !== RV + 32'd8; c++) @(negedge clk);
    total++;
    if (data_write !== 1'b1 || data_read !== 1'b0) begin
      bad++; $display("FAIL sw_strobe got=%b%b want=10", data_write, data_read);
    end
    total++;
    if (data_address !== 32'd4) begin
      bad++; $display("FAIL sw_addr got=%h want=4", data_address);
    end
    total++;
    if (data_writedata !== 32'h12345678) begin
      bad++; $display("FAIL sw_data got=%h want=12345678", data_writedata);
    end
    @(negedge clk);
    total++;
    if (data_read !== 1'b1 || data_write !== 1'b0 || data_address !== 32'd4) begin
      bad++;
      $display("FAIL lw_bus rd=%b wr=%b a=%h want=1/0/4",
               data_read, data_write, data_address);
    end
    wait_halt("ldst");
    total++;
    if (register_v0 !== 32'h12345678) begin
      bad++; $display("FAIL ldst_v0 got=%h want=12345678", register_v0);
    end
  endtask

  task automatic test_jal();
    clear_imem();
    imem[0] = j_t(6'h03, RV + 32'h10);
    imem[1] = 32'd0;
    imem[2] = i_t(6'h09, 5'd2, 5'd2, 16'd1);
    imem[3] = i_t(6'h09, 5'd2, 5'd2, 16'd1);
    imem[4] = r_t(5'd31, 5'd0, 5'd2, 5'd0, 6'h21);
    imem[5] = r_t(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
    do_reset();
    wait_halt("jal");
    total++;
    if (register_v0 !== RV + 32'd8) begin
      bad++; $display("FAIL jal_v0 got=%h want=%h", register_v0, RV + 32'd8);
    end
  endtask

  task automatic test_clk_enable();
    load_count_prog(6'h05, 5'd0, 5'd0);
    do_reset();
    repeat (3) @(negedge clk);
    clk_enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (instr_address !== RV + 32'hC || register_v0 !== 32'd2) begin
        bad++;
        $display("FAIL ce_hold pc=%h v0=%h want=%h/2",
                 instr_address, register_v0, RV + 32'hC);
      end
    end
    clk_enable = 1'b1;
    wait_halt("ce");
    total++;
    if (register_v0 !== 32'd3) begin
      bad++; $display("FAIL ce_v0 got=%h want=3", register_v0);
    end
  endtask

  task automatic test_reset_midrun();
    load_count_prog(6'h05, 5'd0, 5'd0);
    do_reset();
    repeat (2) @(negedge clk);
    do_reset();
    total++;
    if (instr_address !== RV || register_v0 !== 32'd0 || active !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid pc=%h v0=%h act=%b want=%h/0/1",
               instr_address, register_v0, active, RV);
    end
    wait_halt("rst");
    do_reset();
    total++;
    if (instr_address !== RV || register_v0 !== 32'd0 || active !== 1'b1) begin
      bad++;
      $display("FAIL rst_halt pc=%h v0=%h act=%b want=%h/0/1",
               instr_address, register_v0, active, RV);
    end
    @(negedge clk);
    total++;
    if (instr_address !== RV + 32'd4) begin
      bad++; $display("FAIL rst_resume pc=%h want=%h", instr_address, RV + 32'd4);
    end
  endtask

  function automatic logic [4:0] rnd_reg();
    int v;
    v = $urandom_range(0, 9);
    return (v > 7) ? 5'd2 : 5'(v);
  endfunction

  function automatic logic [31:0] rnd_op(input int k);
    logic [4:0]  rs, rt, rd;
    logic [15:0] im;
    logic [5:0]  f;
    rs = rnd_reg(); rt = rnd_reg(); rd = rnd_reg();
    im = 16'($urandom);
    case (k)
      0, 1: begin
        case ($urandom_range(0, 7))
          0: f = 6'h21; 1: f = 6'h23; 2: f = 6'h24; 3: f = 6'h25;
          4: f = 6'h26; 5: f = 6'h27; 6: f = 6'h2A; default: f = 6'h2B;
        endcase
        return r_t(rs, rt, rd, 5'd0, f);
      end
      2: begin
        case ($urandom_range(0, 2))
          0: f = 6'h00; 1: f = 6'h02; default: f = 6'h03;
        endcase
        return r_t(5'd0, rt, rd, 5'($urandom), f);
      end
      3: begin
        case ($urandom_range(0, 2))
          0: f = 6'h04; 1: f = 6'h06; default: f = 6'h07;
        endcase
        return r_t(rs, rt, rd, 5'd0, f);
      end
      6: return i_t(6'h0F, 5'd0, rt, im);
      7: return i_t($urandom_range(0, 1) ? 6'h23 : 6'h2B, rs, rt, im);
      default: begin
        case ($urandom_range(0, 5))
          0: f = 6'h09; 1: f = 6'h0A; 2: f = 6'h0B;
          3: f = 6'h0C; 4: f = 6'h0D; default: f = 6'h0E;
        endcase
        return i_t(f, rs, rt, im);
      end
    endcase
  endfunction

  function automatic logic [31:0] rnd_branch(input int k);
    logic [4:0]  rs, rt;
    logic [15:0] off;
    rs = rnd_reg(); rt = rnd_reg();
    off = 16'(k);
    case ($urandom_range(0, 5))
      0: return i_t(6'h04, rs, rt, off);
      1: return i_t(6'h05, rs, rt, off);
      2: return i_t(6'h06, rs, 5'd0, off);
      3: return i_t(6'h07, rs, 5'd0, off);
      4: return i_t(6'h01, rs, 5'd0, off);
      default: return i_t(6'h01, rs, 5'd1, off);
    endcase
  endfunction

  // Forward branches only, never in a delay slot, never past the JR.
  task automatic gen_program(input int len);
    logic prev_br;
    int   k;
    clear_imem();
    prev_br = 1'b0;
    for (int i = 0; i < len; i++) begin
      k = $urandom_range(0, 9);
      if (k >= 8 && !prev_br && i <= len - 3) begin
        imem[i] = rnd_branch($urandom_range(1, len - 1 - i));
        prev_br = 1'b1;
      end else begin
        imem[i] = rnd_op(k);
        prev_br = 1'b0;
      end
    end
    imem[len] = r_t(5'd0, 5'd0, 5'd0, 5'd0, 6'h08);
    imem[len + 1] = 32'd0;
  endtask

  task automatic test_random();
    logic [31:0] w, ea;
    logic        we, re;
    for (int p = 0; p < 10; p++) begin
      gen_program(24);
      for (int i = 0; i < 64; i++) dm_seed[i] = $urandom;
      do_reset();
      for (int c = 0; c <= 200; c++) begin
        w  = m_fetch(m_pc);
        we = m_active && w[31:26] == 6'h2B;
        re = m_active && w[31:26] == 6'h23;
        ea = m_gpr[w[25:21]] + {{16{w[15]}}, w[15:0]};
        total++;
        if (instr_address !== m_pc) begin
          bad++; $display("FAIL rnd%0d_pc got=%h want=%h", p, instr_address, m_pc);
        end
        total++;
        if (register_v0 !== m_gpr[2]) begin
          bad++;
          $display("FAIL rnd%0d_v0 pc=%h got=%h want=%h",
                   p, m_pc, register_v0, m_gpr[2]);
        end
        total++;
        if (active !== m_active) begin
          bad++; $display("FAIL rnd%0d_active got=%b want=%b", p, active, m_active);
        end
        total++;
        if (data_write !== we || data_read !== re) begin
          bad++;
          $display("FAIL rnd%0d_strobe got=%b%b want=%b%b",
                   p, data_write, data_read, we, re);
        end
        if (we || re) begin
          total++;
          if (data_address !== ea) begin
            bad++; $display("FAIL rnd%0d_addr got=%h want=%h", p, data_address, ea);
          end
        end
        if (we) begin
          total++;
          if (data_writedata !== m_gpr[w[20:16]]) begin
            bad++;
            $display("FAIL rnd%0d_wdata got=%h want=%h",
                     p, data_writedata, m_gpr[w[20:16]]);
          end
        end
        if (!m_active) break;
        if (c == 200) begin
          total++; bad++;
          $display("FAIL rnd%0d_timeout pc=%h want=halt", p, instr_address);
          break;
        end
        model_step();
        @(negedge clk);
      end
    end
  endtask

  initial begin
    clear_imem();
    for (int i = 0; i < 64; i++) dm_seed[i] = 32'd0;
    test_reset();
    test_beq();
    test_bne();
    test_load_store();
    test_jal();
    test_clk_enable();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
